// File: rtl/mult_booth4.sv
// Signed 32x32 radix-4 modified Booth multiplier: 16 iterations of two multiplier bits each,
// low word and overflow flag presented with a one-cycle completion strobe.
module mult_booth4 (
    input  logic        clock,
    input  logic        clr_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [64:0] p;
    logic [31:0] m;

    logic [33:0] m_x1;
    logic [33:0] m_x2;
    logic [33:0] addend;
    logic [33:0] sum;
    logic [64:0] p_next;

    // 34-bit operands keep +/-2M exact even for M = -2^31
    always_comb begin
        m_x1   = {{2{m[31]}}, m};
        m_x2   = {m[31], m, 1'b0};
        addend = '0;
        case (p[2:0])
            3'b001, 3'b010: addend = m_x1;
            3'b011:         addend = m_x2;
            3'b100:         addend = -m_x2;
            3'b101, 3'b110: addend = -m_x1;
            default:        addend = '0;
        endcase
        sum    = {{2{p[64]}}, p[64:33]} + addend;
        p_next = {sum, p[32:2]};
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= '0;
            m     <= '0;
        end else if (ctrl_MULT) begin
            // a start edge wins in every state and discards any operation in flight
            state <= RUN;
            cnt   <= '0;
            p     <= {32'b0, data_operandB, 1'b0};
            m     <= data_operandA;
        end else begin
            case (state)
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign data_result    = p[32:1];
    assign data_exception = (p[64:33] != {32{p[32]}});
    assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_mult_booth4.sv
// Scoreboard bench for mult_booth4: directed products with hand-computed results, strobe
// timing, restart/abort, held start and mid-run reset behaviour.
module tb_mult_booth4;

    logic        clock;
    logic        clr_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    mult_booth4 dut (
        .clock          (clock),
        .clr_n          (clr_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_cnt = 0;
    logic [31:0] last_res;
    logic        last_exc;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expectation, including its edge.
    always @(negedge clock) begin
        if (clr_n === 1'b1 && data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe at edge %0d, expected none", edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'b0, data_exception}, {31'b0, e.exc});
                check("strobe_edge", edge_cnt, e.due);
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push,
                            input logic [31:0] res, input logic exc);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        if (push) begin
            e.res = res; e.exc = exc; e.due = edge_cnt + 1 + 16;
            sb.push_back(e);
            last_res = res; last_exc = exc;
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
        start_op(a, b, 1'b1, res, exc);
        wait_done();
    endtask

    initial begin
        exp_t e;
        clr_n = 1'b1;
        ctrl_MULT = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #2 clr_n = 1'b0;
        #1;
        check("reset_result", data_result, 32'h0);
        check("reset_exception", {31'b0, data_exception}, 32'h0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        repeat (2) @(negedge clock);
        clr_n = 1'b1;

        run_op(32'd3,        32'd5,        32'h0000000F, 1'b0);
        check("hold_result", data_result, last_res);
        check("hold_exception", {31'b0, data_exception}, {31'b0, last_exc});
        run_op(-32'sd7,      32'd6,        32'hFFFFFFD6, 1'b0);
        run_op(32'h80000000, 32'd1,        32'h80000000, 1'b0);
        run_op(32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1);
        run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op(32'd0,        32'h12345678, 32'h00000000, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op(32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run_op(32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
        run_op(32'h80000000, 32'd2,        32'h00000000, 1'b1);
        run_op(32'd12345,    -32'sd678,    32'hFF80490A, 1'b0);
        repeat (3) @(negedge clock);
        check("idle_hold_result", data_result, last_res);

        // restart at edge 8 of a 3x5: only the 4x4 may strobe
        start_op(32'd3, 32'd5, 1'b0, '0, 1'b0);
        repeat (6) @(negedge clock);
        run_op(32'd4, 32'd4, 32'h00000010, 1'b0);

        // start held for three edges: timing counts from the last one
        @(negedge clock);
        data_operandA = 32'd6;
        data_operandB = 32'd7;
        ctrl_MULT = 1'b1;
        repeat (3) @(negedge clock);
        e.res = 32'h0000002A; e.exc = 1'b0; e.due = edge_cnt + 16;
        sb.push_back(e);
        ctrl_MULT = 1'b0;
        wait_done();

        // reset mid-run, then start 2x2 on the first edge after release
        start_op(32'd3, 32'd5, 1'b0, '0, 1'b0);
        repeat (4) @(negedge clock);
        #1 clr_n = 1'b0;
        #1;
        check("midrun_reset_result", data_result, 32'h0);
        check("midrun_reset_exception", {31'b0, data_exception}, 32'h0);
        check("midrun_reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        data_operandA = 32'd2;
        data_operandB = 32'd2;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        check("in_reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        clr_n = 1'b1;
        e.res = 32'h00000004; e.exc = 1'b0; e.due = edge_cnt + 1 + 16;
        sb.push_back(e);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_done();

        repeat (4) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_booth4.md
MULT_BOOTH4 -- requirements
Module: mult_booth4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and the product register at 65 bits.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port ctrl_MULT, input, 1 bit, the start pulse; it is sampled on the rising edge.
REQ-005 The block SHALL have port data_operandA, input, 32 bits, the signed multiplicand.
REQ-006 The block SHALL have port data_operandB, input, 32 bits, the signed multiplier.
REQ-007 The block SHALL have port data_result, output, 32 bits, the low 32 bits of the signed product.
REQ-008 The block SHALL have port data_exception, output, 1 bit, set when the product does not fit in signed 32 bits.
REQ-009 The block SHALL have port data_resultRDY, output, 1 bit, a one-cycle completion strobe.

Function
REQ-010 The block SHALL implement radix-4 modified Booth multiplication over a 65-bit product register P.
- P[64:33] = partial high word.
- P[32:1] = multiplier and low product bits.
- P[0] = Booth extra bit.
REQ-011 The FSM SHALL have three states (IDLE, RUN, DONE) and a 4-bit iteration counter.
REQ-012 Start: when ctrl_MULT=1 on an edge, in any state, the block SHALL:
- latch M = data_operandA;
- load P = {32'b0, data_operandB, 1'b0};
- clear the counter;
- enter RUN.
This aborts any operation in progress.
REQ-013 In each RUN cycle, P[2:0] SHALL select the addend:
- 000 or 111: 0
- 001 or 010: +M
- 011: +2M
- 100: -2M
- 101 or 110: -M
REQ-014 The add SHALL be 34 bits wide: the sign-extended P[64:33] plus the sign-extended addend. The next value of P SHALL be bits [66:2] of {sum34, P[32:0]}, i.e. an arithmetic shift right by 2.
REQ-015 M = 0x80000000 with ±2M SHALL be computed exactly; the 34-bit width guarantees no intermediate overflow.
REQ-016 RUN SHALL last exactly 16 cycles. On the 16th iteration edge the FSM SHALL go to DONE; DONE SHALL return to IDLE on the next edge unless ctrl_MULT=1 is sampled on that edge.
REQ-017 data_resultRDY SHALL be 1 only while in DONE. With ctrl_MULT sampled on edge 0, it is high in the cycle following edge 16.
REQ-018 data_result SHALL equal P[32:1] at all times; only its value while data_resultRDY=1 (and after, until the next start) is meaningful.
REQ-019 data_exception SHALL be 1 when P[64:33] is not the 32-fold replication of P[32]; it is meaningful under the same rule as data_result.
REQ-020 Result and exception SHALL hold stable after DONE until the next start or reset.
REQ-021 ctrl_MULT held high for multiple cycles SHALL restart the operation on each sampled edge; no result is produced until it deasserts.
REQ-022 Operand inputs SHALL be ignored except on a start edge.

Reset
REQ-023 While clr_n=0, state SHALL be IDLE, counter 0, P = 0 and M = 0, independent of clock.
REQ-024 While clr_n=0, data_result=0, data_exception=0 and data_resultRDY=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no data_resultRDY pulse; the first edge after release, with ctrl_MULT=1, SHALL start cleanly.

Verification
REQ-026 A=3, B=5, start at edge 0 -> data_resultRDY high exactly one cycle after edge 16; result 0x0000000F; exception 0.
REQ-027 A=-7, B=6 -> result 0xFFFFFFD6 (-42); exception 0. A=0x80000000, B=1 -> result 0x80000000; exception 0.
REQ-028 Overflow cases:
- A=0x7FFFFFFF, B=2 -> result 0xFFFFFFFE; exception 1.
- A=0x80000000, B=0xFFFFFFFF -> result 0x80000000; exception 1.
REQ-029 Start 3x5, then start 4x4 at edge 8 -> no strobe for 3x5; single strobe after edge 24 with result 0x00000010.
REQ-030 Start 3x5, pulse clr_n low at cycle 5 -> outputs 0 immediately; no strobe; a following 2x2 start gives result 4 after 16 iterations.
